// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU control unit: widths, opcodes, state codes,
// instruction field positions and the decoded-instruction record.
package cpu_pkg;

  localparam int PC_W    = 4;
  localparam int DATA_W  = 4;
  localparam int REG_AW  = 2;
  localparam int CNT_W   = 8;
  localparam int INSTR_W = 10;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int OP_MSB   = 9;
  localparam int OP_LSB   = 8;
  localparam int FUNC_MSB = 7;
  localparam int FUNC_LSB = 6;
  localparam int WA_MSB   = 5;
  localparam int WA_LSB   = 4;
  localparam int RA1_MSB  = 3;
  localparam int RA1_LSB  = 2;
  localparam int RA2_MSB  = 1;
  localparam int RA2_LSB  = 0;
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;

  typedef struct packed {
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [REG_AW-1:0] wa;
    logic [1:0]        func;
    logic              mux_sel;
    logic [DATA_W-1:0] imm;
    logic              is_write;
    logic              is_jmp;
    logic              is_halt;
  } decode_t;

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational instruction decoder: splits an instruction word into register
// addresses, ALU function, immediate/target and the class flags used by the sequencer.
module cpu_instr_decoder
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  output decode_t            dec_o
);

  logic [1:0] op;

  always_comb begin
    op            = ir_i[OP_MSB:OP_LSB];
    dec_o         = '0;
    dec_o.ra1     = ir_i[RA1_MSB:RA1_LSB];
    dec_o.ra2     = ir_i[RA2_MSB:RA2_LSB];
    dec_o.wa      = ir_i[WA_MSB:WA_LSB];
    dec_o.func    = ir_i[FUNC_MSB:FUNC_LSB];
    dec_o.imm     = ir_i[IMM_MSB:IMM_LSB];
    // The write mux takes the ALU result only for ALU ops; LDI writes the immediate.
    dec_o.mux_sel  = (op == OP_ALU);
    dec_o.is_write = (op == OP_ALU) || (op == OP_LDI);
    dec_o.is_jmp   = (op == OP_JMP);
    dec_o.is_halt  = (op == OP_HALT);
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the 4-bit CPU: FETCH/DECODE/EXEC/WB per instruction,
// JMP retires from EXEC, HALT is sticky until reset.
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    instrAddr,
  input  logic [INSTR_W-1:0] instrData,
  output logic [REG_AW-1:0]  readAddr1,
  output logic [REG_AW-1:0]  readAddr2,
  output logic [REG_AW-1:0]  writeAddr,
  output logic               writeEn,
  output logic [1:0]         aluFunc,
  output logic               muxSelect,
  output logic [DATA_W-1:0]  exWriteData,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired,
  output logic [2:0]         dbgState
);

  logic [2:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  decode_t            dec_q, dec_d;
  decode_t            dec_w;

  cpu_instr_decoder u_decoder (
    .ir_i  (ir_q),
    .dec_o (dec_w)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    dec_d     = dec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_d    = instrData;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Datapath controls are registered here and held until the next DECODE.
        dec_d   = dec_w;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_q.is_halt) begin
          state_d = S_HALT;
        end else if (dec_q.is_jmp) begin
          pc_d      = PC_W'(dec_q.imm);
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else if (dec_q.is_write) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        pc_d      = pc_q + PC_W'(1);
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
      dec_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      dec_q     <= dec_d;
    end
  end

  // writeEn is decoded from the state register so an async reset clears it at once.
  assign writeEn     = (state_q == S_WB);
  assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXEC)  || (state_q == S_WB);
  assign halted      = (state_q == S_HALT);
  assign instrAddr   = pc_q;
  assign retired     = retired_q;
  assign readAddr1   = dec_q.ra1;
  assign readAddr2   = dec_q.ra2;
  assign writeAddr   = dec_q.wa;
  assign aluFunc     = dec_q.func;
  assign muxSelect   = dec_q.mux_sel;
  assign exWriteData = dec_q.imm;
  assign dbgState    = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: vector table, hand-written corner
// sequences and random programs scored against an instruction-level timeline model.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] instrAddr;
  logic [9:0] instrData;
  logic [1:0] readAddr1, readAddr2, writeAddr;
  logic       writeEn;
  logic [1:0] aluFunc;
  logic       muxSelect;
  logic [3:0] exWriteData;
  logic       busy, halted;
  logic [7:0] retired;
  logic [2:0] dbgState;

  cpu_control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .instrAddr   (instrAddr),
    .instrData   (instrData),
    .readAddr1   (readAddr1),
    .readAddr2   (readAddr2),
    .writeAddr   (writeAddr),
    .writeEn     (writeEn),
    .aluFunc     (aluFunc),
    .muxSelect   (muxSelect),
    .exWriteData (exWriteData),
    .busy        (busy),
    .halted      (halted),
    .retired     (retired),
    .dbgState    (dbgState)
  );

  // clock / reset / instruction memory
  always #5 clk = ~clk;

  logic [9:0] mem [16];
  assign instrData = mem[instrAddr];

  localparam logic [9:0] HALT_W = 10'b11_0000_0000;
  localparam int         RW     = 120;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // scoreboard: packed write records {cycle, wa, mux, imm, func, ra1, ra2}
  logic [20:0] exp_q[$];
  logic [20:0] act_q[$];

  // timeline model outputs, indexed by cycle after start
  int m_pc  [256];
  int m_ret [256];
  bit m_busy[256];
  bit m_halt[256];
  bit m_we  [256];

  typedef struct {
    logic [9:0]  instr;
    int          n_wr;
    logic [20:0] wr;
    int          fin_pc;
    int          fin_ret;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [20:0] pack_wr(int c, logic [1:0] wa, logic mux, logic [3:0] imm,
                                          logic [1:0] func, logic [1:0] ra1, logic [1:0] ra2);
    if (mux) return {8'(c), wa, 1'b1, 4'b0000, func, ra1, ra2};
    return {8'(c), wa, 1'b0, imm, 6'b000000};
  endfunction

  function automatic logic [9:0] rand_instr();
    int         r = $urandom_range(0, 15);
    logic [7:0] f = 8'($urandom);
    logic [1:0] op;
    if (r == 0)      op = 2'b11;
    else if (r <= 2) op = 2'b10;
    else if (r <= 8) op = 2'b01;
    else             op = 2'b00;
    return {op, f};
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (writeEn)
      act_q.push_back(pack_wr(cyc, writeAddr, muxSelect, exWriteData, aluFunc, readAddr1, readAddr2));
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic go();
    cyc   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 16; i++) mem[i] = HALT_W;
  endtask

  task automatic compare_writes(string name);
    logic [20:0] e, a;
    check({name, "_count"}, act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      check(name, a, e);
    end
    exp_q.delete();
    act_q.delete();
  endtask

  // Instruction-level model: each instruction occupies 4 cycles (ALU/LDI, write in
  // the last) or 3 (JMP); HALT is busy for 3 cycles then halted forever.
  task automatic run_model(int w);
    int         c, pc, ret, len;
    logic [9:0] ins;
    for (int k = 0; k < 256; k++) begin
      m_pc[k] = 0; m_ret[k] = 0; m_busy[k] = 0; m_halt[k] = 0; m_we[k] = 0;
    end
    c = 1; pc = 0; ret = 0;
    while (c <= w) begin
      ins = mem[pc];
      if (ins[9:8] == 2'b11) begin
        for (int k = c; k <= w; k++) begin
          m_pc[k] = pc; m_ret[k] = ret; m_busy[k] = (k < c + 3); m_halt[k] = (k >= c + 3);
        end
        break;
      end
      len = (ins[9:8] == 2'b10) ? 3 : 4;
      for (int k = c; k < c + len && k <= w; k++) begin
        m_pc[k] = pc; m_ret[k] = ret; m_busy[k] = 1; m_we[k] = (len == 4 && k == c + 3);
      end
      if (len == 4 && c + 3 <= w)
        exp_q.push_back(pack_wr(c + 3, ins[5:4], ins[9:8] == 2'b00, ins[3:0], ins[7:6], ins[3:2], ins[1:0]));
      ret = (ret + 1) % 256;
      pc  = (ins[9:8] == 2'b10) ? int'(ins[3:0]) : (pc + 1) % 16;
      c  += len;
    end
  endtask

  initial begin
    int xcnt;
    reset = 1'b1;
    start = 1'b0;
    fill_halt();

    // reset state
    #12;
    check("rst_writeEn", writeEn, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_instrAddr", instrAddr, 0);
    check("rst_retired", retired, 0);
    check("rst_ctrl", {readAddr1, readAddr2, writeAddr, aluFunc, muxSelect, exWriteData}, 0);

    // vector table: one instruction at PC 0, HALT everywhere else
    vecs[0] = '{10'b01_00_10_1001, 1, pack_wr(4, 2'd2, 1'b0, 4'd9,  2'd0, 2'd0, 2'd0), 1,  1};
    vecs[1] = '{10'b01_00_00_1111, 1, pack_wr(4, 2'd0, 1'b0, 4'd15, 2'd0, 2'd0, 2'd0), 1,  1};
    vecs[2] = '{10'b00_11_01_11_00, 1, pack_wr(4, 2'd1, 1'b1, 4'd0, 2'd3, 2'd3, 2'd0), 1,  1};
    vecs[3] = '{10'b00_10_11_10_01, 1, pack_wr(4, 2'd3, 1'b1, 4'd0, 2'd2, 2'd2, 2'd1), 1,  1};
    vecs[4] = '{10'b10_00_00_0111, 0, 21'd0, 7,  1};
    vecs[5] = '{10'b10_11_11_1111, 0, 21'd0, 15, 1};
    vecs[6] = '{10'b11_11_11_1111, 0, 21'd0, 0,  0};
    for (int v = 0; v < 7; v++) begin
      fill_halt();
      mem[0] = vecs[v].instr;
      do_reset();
      if (vecs[v].n_wr == 1) exp_q.push_back(vecs[v].wr);
      go();
      while (cyc < 12) tick();
      check("vec_halted", halted, 1);
      check("vec_busy", busy, 0);
      check("vec_pc", instrAddr, vecs[v].fin_pc);
      check("vec_retired", retired, vecs[v].fin_ret);
      compare_writes("vec_wr");
    end

    // reset during the second write-back aborts it at once
    fill_halt();
    mem[0] = 10'b01_00_01_0101;
    mem[1] = 10'b01_00_10_0011;
    do_reset();
    go();
    while (cyc < 8) tick();
    check("t1_we_before", writeEn, 1);
    check("t1_pc_before", instrAddr, 1);
    reset = 1'b1;
    #1;
    check("t1_we_rst", writeEn, 0);
    check("t1_busy_rst", busy, 0);
    check("t1_pc_rst", instrAddr, 0);
    check("t1_ret_rst", retired, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    act_q.delete();
    repeat (3) tick();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_halted", halted, 0);
    check("t1_idle_pc", instrAddr, 0);
    go();
    while (cyc < 4) tick();
    check("t1_restart_we", writeEn, 1);
    check("t1_restart_wa", writeAddr, 1);

    // LDI r1,5; LDI r2,3; ADD r3=r1+r2; HALT
    fill_halt();
    mem[0] = 10'b01_00_01_0101;
    mem[1] = 10'b01_00_10_0011;
    mem[2] = 10'b00_00_11_01_10;
    do_reset();
    exp_q.push_back(pack_wr(4,  2'd1, 1'b0, 4'd5, 2'd0, 2'd0, 2'd0));
    exp_q.push_back(pack_wr(8,  2'd2, 1'b0, 4'd3, 2'd0, 2'd0, 2'd0));
    exp_q.push_back(pack_wr(12, 2'd3, 1'b1, 4'd0, 2'd0, 2'd1, 2'd2));
    go();
    while (cyc < 20) tick();
    compare_writes("t2_wr");
    check("t2_halted", halted, 1);
    check("t2_retired", retired, 3);
    check("t2_pc", instrAddr, 3);

    // HALT is sticky against start
    for (int i = 0; i < 10; i++) begin
      start = 1'(i % 2 == 0);
      tick();
      check("t5_halted", halted, 1);
      check("t5_pc", instrAddr, 3);
      check("t5_retired", retired, 3);
    end
    start = 1'b0;
    compare_writes("t5_wr");

    // JMP 4 at PC 0, HALT at PC 4
    fill_halt();
    mem[0] = 10'b10_00_00_0100;
    do_reset();
    go();
    check("t3_busy", busy, 1);
    while (cyc < 3) tick();
    check("t3_pc_c3", instrAddr, 0);
    check("t3_ret_c3", retired, 0);
    tick();
    check("t3_pc_c4", instrAddr, 4);
    check("t3_ret_c4", retired, 1);
    while (cyc < 10) tick();
    check("t3_halted", halted, 1);
    check("t3_pc_end", instrAddr, 4);
    compare_writes("t3_wr");

    // 15 LDIs then JMP 0 at PC 15
    for (int i = 0; i < 15; i++) mem[i] = {2'b01, 2'b00, 2'(i % 4), 4'(i)};
    mem[15] = 10'b10_00_00_0000;
    do_reset();
    for (int i = 0; i < 15; i++) exp_q.push_back(pack_wr(4 + 4 * i, 2'(i % 4), 1'b0, 4'(i), 2'd0, 2'd0, 2'd0));
    xcnt = 0;
    go();
    while (cyc < 64) begin
      if ($isunknown({instrAddr, readAddr1, readAddr2, writeAddr, writeEn, aluFunc,
                      muxSelect, exWriteData, busy, halted, retired})) xcnt++;
      tick();
    end
    check("t4_pc", instrAddr, 0);
    check("t4_retired", retired, 16);
    check("t4_busy", busy, 1);
    check("t4_no_x", xcnt, 0);
    compare_writes("t4_wr");

    // 16 LDIs: PC 15 + 1 wraps to 0
    for (int i = 0; i < 16; i++) mem[i] = {2'b01, 2'b00, 2'(i % 4), 4'(15 - i)};
    do_reset();
    go();
    while (cyc < 65) tick();
    check("t4b_pc_wrap", instrAddr, 0);
    check("t4b_retired", retired, 16);

    // random programs with start toggled throughout
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 16; i++) mem[i] = rand_instr();
      do_reset();
      run_model(RW);
      go();
      for (int c = 1; c <= RW; c++) begin
        check("rnd_pc", instrAddr, m_pc[c]);
        check("rnd_retired", retired, m_ret[c]);
        check("rnd_busy", busy, m_busy[c]);
        check("rnd_halted", halted, m_halt[c]);
        check("rnd_writeEn", writeEn, m_we[c]);
        if (c < RW) begin
          start = 1'($urandom_range(0, 1));
          tick();
        end
      end
      start = 1'b0;
      compare_writes("rnd_wr");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
